// File: rtl/period_to_rpm_pkg.sv
// Shared types, defaults and the period classifier for the period -> rpm converter.
`include "rpm_config.sv"

package period_to_rpm_pkg;

    localparam int DEF_RPM_WIDTH      = `RPM_WIDTH;
    localparam int DEF_CLK_HZ         = `RPM_CLK_HZ;
    localparam int DEF_PULSES_PER_REV = `RPM_PULSES_PER_REV;
    localparam int DEF_STALL_PERIOD   = `RPM_STALL_PERIOD;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_DIV  = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        CLS_NORM  = 2'd0,
        CLS_ZERO  = 2'd1,
        CLS_STALL = 2'd2
    } cls_t;

    // Zero and stalled periods bypass the divider and report rpm = 0.
    function automatic cls_t classify_period(input longint unsigned p,
                                             input longint unsigned stall_p);
        cls_t c;
        c = CLS_NORM;
        if (p == 64'd0)
            c = CLS_ZERO;
        else if (p >= stall_p)
            c = CLS_STALL;
        return c;
    endfunction

endpackage

// File: rtl/period_to_rpm_if.sv
// Period input / rpm output bundle between the pulse timer, this block and the display stage.
interface period_to_rpm_if #(
    parameter int W = 16
);
    logic [W-1:0] period;
    logic         period_change;
    logic [W-1:0] rpm;
    logic         rpm_valid;
    logic         busy;
    logic         zero_period;
    logic         stalled;

    modport master (
        output period, period_change,
        input  rpm, rpm_valid, busy, zero_period, stalled
    );

    modport slave (
        input  period, period_change,
        output rpm, rpm_valid, busy, zero_period, stalled
    );
endinterface

// File: rtl/rpm_config.sv
// Shared build-time defaults for the tachometer chain (pulse timer -> period_to_rpm).
`ifndef RPM_CONFIG_SV
`define RPM_CONFIG_SV
`define RPM_WIDTH          16
`define RPM_CLK_HZ         1000
`define RPM_PULSES_PER_REV 1
`define RPM_STALL_PERIOD   30000
`endif

// File: rtl/rpm_divider.sv
// Multi-cycle restoring divider: one quotient bit per clock, W clocks per division.
module rpm_divider
#(
    parameter int W = 16
)(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] quotient,
    output logic         done
);

    localparam int CW = $clog2(W + 1);

    logic          r_active;
    logic [CW-1:0] r_cnt;
    logic [W-1:0]  r_rem;
    logic [W-1:0]  r_dvd;
    logic [W-2:0]  r_quo;

    logic [W:0]    w_shift;
    logic          w_fit;
    logic [W-1:0]  w_diff;
    logic [W-1:0]  w_quo_nxt;

    // Remainder stays below the divisor, so the subtraction never needs bit W.
    assign w_shift   = {r_rem, r_dvd[W-1]};
    assign w_fit     = (w_shift >= {1'b0, divisor});
    assign w_diff    = w_shift[W-1:0] - divisor;
    assign w_quo_nxt = {r_quo, w_fit};

    // The final quotient is taken combinationally on the last step, so the
    // stored partial quotient never needs its top bit.
    assign quotient  = w_quo_nxt;
    assign done      = r_active && (r_cnt == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_active <= 1'b0;
            r_cnt    <= '0;
            r_rem    <= '0;
            r_dvd    <= '0;
            r_quo    <= '0;
        end else if (start) begin
            r_active <= 1'b1;
            r_cnt    <= CW'(W - 1);
            r_rem    <= '0;
            r_dvd    <= dividend;
            r_quo    <= '0;
        end else if (r_active) begin
            r_rem    <= w_fit ? w_diff : w_shift[W-1:0];
            r_dvd    <= {r_dvd[W-2:0], 1'b0};
            r_quo    <= w_quo_nxt[W-2:0];
            r_cnt    <= r_cnt - 1'b1;
            if (r_cnt == '0)
                r_active <= 1'b0;
        end
    end

endmodule

// File: rtl/period_to_rpm.sv
// Converts the pulse timer's averaged period into rpm = NUMERATOR / period with a one-cycle valid strobe.
module period_to_rpm
    import period_to_rpm_pkg::*;
#(
    parameter int RPM_WIDTH      = DEF_RPM_WIDTH,
    parameter int CLK_HZ         = DEF_CLK_HZ,
    parameter int PULSES_PER_REV = DEF_PULSES_PER_REV,
    parameter int STALL_PERIOD   = DEF_STALL_PERIOD
)(
    input  logic           clk,
    input  logic           rst_n,
    period_to_rpm_if.slave bus
);

    localparam longint unsigned NUMERATOR = (PULSES_PER_REV > 0) ?
        (longint'(CLK_HZ) * 64'd60) / longint'(PULSES_PER_REV) : 64'd0;
    localparam logic [RPM_WIDTH-1:0] NUM_W = RPM_WIDTH'(NUMERATOR);

    if (PULSES_PER_REV < 1) begin : g_ppr_chk
        $error("period_to_rpm: PULSES_PER_REV must be >= 1");
    end
    if (NUMERATOR >= (64'd1 << RPM_WIDTH)) begin : g_num_chk
        $error("period_to_rpm: NUMERATOR does not fit in RPM_WIDTH");
    end
    if (STALL_PERIOD < 1) begin : g_stall_chk
        $error("period_to_rpm: STALL_PERIOD must be >= 1");
    end

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_chg_q;
    logic [RPM_WIDTH-1:0] r_div_q;
    logic                 r_pend_zero;
    logic                 r_pend_stall;
    logic [RPM_WIDTH-1:0] r_rpm;
    logic                 r_rpm_valid;
    logic                 r_zero;
    logic                 r_stall;

    logic                 w_event;
    cls_t                 w_cls;
    logic                 w_start;
    logic                 w_div_done;
    logic [RPM_WIDTH-1:0] w_quot;

    assign w_event = (bus.period_change != r_chg_q);
    assign w_cls   = classify_period(64'(bus.period), 64'(STALL_PERIOD));

    rpm_divider #(.W(RPM_WIDTH)) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (w_start),
        .dividend (NUM_W),
        .divisor  (r_div_q),
        .quotient (w_quot),
        .done     (w_div_done)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_event && (w_cls == CLS_NORM)) begin
                    w_start     = 1'b1;
                    w_state_nxt = ST_DIV;
                end
            end
            ST_DIV: begin
                if (w_div_done)
                    w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_chg_q <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_chg_q <= bus.period_change;
        end
    end

    // Events seen during DIV are dropped; the timer keeps toggling, so the next
    // IDLE event picks up a fresh period anyway.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_div_q      <= '0;
            r_pend_zero  <= 1'b0;
            r_pend_stall <= 1'b0;
            r_rpm        <= '0;
            r_rpm_valid  <= 1'b0;
            r_zero       <= 1'b0;
            r_stall      <= 1'b0;
        end else begin
            r_rpm_valid  <= 1'b0;
            r_pend_zero  <= 1'b0;
            r_pend_stall <= 1'b0;
            if ((r_state == ST_IDLE) && w_event) begin
                r_div_q      <= bus.period;
                r_pend_zero  <= (w_cls == CLS_ZERO);
                r_pend_stall <= (w_cls == CLS_STALL);
            end
            if (r_pend_zero || r_pend_stall) begin
                r_rpm       <= '0;
                r_rpm_valid <= 1'b1;
                r_zero      <= r_pend_zero;
                r_stall     <= r_pend_stall;
            end
            if ((r_state == ST_DIV) && w_div_done) begin
                r_rpm       <= w_quot;
                r_rpm_valid <= 1'b1;
                r_zero      <= 1'b0;
                r_stall     <= 1'b0;
            end
        end
    end

    assign bus.rpm         = r_rpm;
    assign bus.rpm_valid   = r_rpm_valid;
    assign bus.busy        = (r_state == ST_DIV);
    assign bus.zero_period = r_zero;
    assign bus.stalled     = r_stall;

endmodule

// File: tb/tb_period_to_rpm.sv
// Directed bench for period_to_rpm with a timeline model checked every cycle.
module tb_period_to_rpm;

    localparam int     W     = 16;
    localparam longint NUM   = 60000;
    localparam longint STALL = 30000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    period_to_rpm_if #(.W(W)) bus ();

    period_to_rpm #(
        .RPM_WIDTH      (W),
        .CLK_HZ         (1000),
        .PULSES_PER_REV (1),
        .STALL_PERIOD   (30000)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int     n_chk  = 0;
    int     n_fail = 0;
    longint cyc    = 0;
    longint ev_cyc = 0;

    // Model: a result is scheduled for a future edge; events are accepted only
    // once the previous conversion has finished.
    logic   m_prev  = 1'b0;
    longint m_free  = 0;
    longint m_sched = 0;
    logic   m_has   = 1'b0;
    logic   m_norm  = 1'b0;
    longint m_res   = 0;
    logic   m_rz    = 1'b0;
    logic   m_rs    = 1'b0;
    longint m_rpm   = 0;
    logic   m_valid = 1'b0;
    logic   m_busy  = 1'b0;
    logic   m_zero  = 1'b0;
    logic   m_stall = 1'b0;

    longint vq_rpm[$];
    longint vq_cyc[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
        end
    endtask

    always begin
        longint p;
        @(posedge clk);
        cyc++;
        if (!rst_n) begin
            m_prev = 1'b0; m_free = 0; m_has = 1'b0; m_norm = 1'b0;
            m_rpm = 0; m_valid = 1'b0; m_zero = 1'b0; m_stall = 1'b0;
        end else begin
            m_valid = 1'b0;
            if (m_has && cyc == m_sched) begin
                m_rpm = m_res; m_zero = m_rz; m_stall = m_rs;
                m_valid = 1'b1; m_has = 1'b0;
            end
            if (bus.period_change != m_prev && cyc >= m_free) begin
                p = longint'(bus.period);
                m_has = 1'b1;
                if (p == 0) begin
                    m_sched = cyc + 1; m_free = cyc + 1; m_norm = 1'b0;
                    m_res = 0; m_rz = 1'b1; m_rs = 1'b0;
                end else if (p >= STALL) begin
                    m_sched = cyc + 1; m_free = cyc + 1; m_norm = 1'b0;
                    m_res = 0; m_rz = 1'b0; m_rs = 1'b1;
                end else begin
                    m_sched = cyc + W; m_free = cyc + W + 1; m_norm = 1'b1;
                    m_res = NUM / p; m_rz = 1'b0; m_rs = 1'b0;
                end
            end
            m_prev = bus.period_change;
        end
        m_busy = m_has && m_norm;
        #1;
        chk("rpm",         32'(bus.rpm),         32'(m_rpm));
        chk("rpm_valid",   32'(bus.rpm_valid),   32'(m_valid));
        chk("busy",        32'(bus.busy),        32'(m_busy));
        chk("zero_period", 32'(bus.zero_period), 32'(m_zero));
        chk("stalled",     32'(bus.stalled),     32'(m_stall));
        if (bus.rpm_valid === 1'b1) begin
            vq_rpm.push_back(longint'(bus.rpm));
            vq_cyc.push_back(cyc);
        end
    end

    task automatic toggle(input int p);
        @(negedge clk);
        bus.period        = p[W-1:0];
        bus.period_change = ~bus.period_change;
        ev_cyc            = cyc + 1;
    endtask

    task automatic run(input string nm, input int p, input int exp_rpm,
                       input int exp_lat, input bit ez, input bit es);
        int n;
        vq_rpm.delete(); vq_cyc.delete();
        toggle(p);
        n = 0;
        while (vq_rpm.size() == 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (vq_rpm.size() == 0) begin
            chk({nm, " timeout"}, 32'd0, 32'd1);
        end else begin
            chk({nm, " rpm"},     32'(vq_rpm[0]),          32'(exp_rpm));
            chk({nm, " latency"}, 32'(vq_cyc[0] - ev_cyc), 32'(exp_lat));
            chk({nm, " zero"},    32'(bus.zero_period),    32'(ez));
            chk({nm, " stall"},   32'(bus.stalled),        32'(es));
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        bus.period        = '0;
        bus.period_change = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset rpm",       32'(bus.rpm),         32'd0);
        chk("reset rpm_valid", 32'(bus.rpm_valid),   32'd0);
        chk("reset busy",      32'(bus.busy),        32'd0);
        chk("reset zero",      32'(bus.zero_period), 32'd0);
        chk("reset stalled",   32'(bus.stalled),     32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run("p100",   100,   600,   16, 1'b0, 1'b0);
        run("p7",     7,     8571,  16, 1'b0, 1'b0);
        run("p1",     1,     60000, 16, 1'b0, 1'b0);
        run("p0",     0,     0,     1,  1'b1, 1'b0);
        run("p30000", 30000, 0,     1,  1'b0, 1'b1);
        run("p29999", 29999, 2,     16, 1'b0, 1'b0);
        run("p65535", 65535, 0,     1,  1'b0, 1'b1);
        run("p0b",    0,     0,     1,  1'b1, 1'b0);
        run("p60000", 60000, 0,     1,  1'b0, 1'b1);
        run("p3",     3,     20000, 16, 1'b0, 1'b0);

        // Toggle every cycle; period switches to 200 mid-way through the first division.
        vq_rpm.delete(); vq_cyc.delete();
        for (int i = 0; i < 90; i++)
            toggle(i < 8 ? 100 : 200);
        repeat (25) @(negedge clk);
        chk("stream count", 32'(vq_rpm.size()), 32'd6);
        if (vq_rpm.size() >= 2) begin
            chk("stream first",  32'(vq_rpm[0]), 32'd600);
            chk("stream second", 32'(vq_rpm[1]), 32'd300);
            for (int i = 1; i < vq_cyc.size(); i++)
                chk("stream spacing", 32'(vq_cyc[i] - vq_cyc[i-1]), 32'd17);
        end

        // Reset in the middle of a division.
        vq_rpm.delete(); vq_cyc.delete();
        toggle(100);
        repeat (5) @(negedge clk);
        chk("pre-reset busy", 32'(bus.busy), 32'd1);
        rst_n             = 1'b0;
        bus.period_change = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid reset rpm",  32'(bus.rpm),       32'd0);
        chk("mid reset busy", 32'(bus.busy),      32'd0);
        chk("mid reset vld",  32'(bus.rpm_valid), 32'd0);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        chk("no valid after abort", 32'(vq_rpm.size()), 32'd0);
        run("resume p200", 200, 300, 16, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
